de2_115_stopwatch_ctrl: RTL and testbench
=========================================

Name: de2_115_stopwatch_ctrl

Overview:
Stopwatch sequencer for the DE2-115 board. It consumes the one-cycle pressed pulses from the button synchronizer and runs a START/STOP/LAP/CLEAR state machine. It keeps an 8-digit BCD time count (HH:MM:SS.cc) and outputs the digits, either live or lap-frozen, for the HEX0..HEX7 decoders and status for LEDG.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz (centiseconds); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
rst_n  input  1  synchronous active-low reset
start_stop  input  1  one-cycle pulse (key_pressed[0]); toggles run/pause
lap  input  1  one-cycle pulse (key_pressed[1]); toggles lap freeze while running
clear  input  1  one-cycle pulse (key_pressed[2]); zeroes the count when not running
digits  output  32  display BCD, nibble k drives HEXk: [3:0] cs units, [7:4] cs tens, [11:8] s units, [15:12] s tens, [19:16] min units, [23:20] min tens, [27:24] h units, [31:28] h tens
running  output  1  1 in RUN state
lap_active  output  1  1 while the display is frozen
ovf  output  1  sticky; set on wrap from 99:59:59.99

Behaviour:
- Clock/reset: one clock `clk`. Reset is synchronous and active-low (`rst_n`), sampled on the rising edge of `clk`.
- Reset (rst_n=0 at an edge): state=IDLE, prescaler=0, count=0, lap latch=0, digits=0, running=0, lap_active=0, ovf=0. Reset mid-run has the same effect; no pending state survives.
- States:
  - IDLE: count is zero, stopped.
  - RUN: counting.
  - PAUSE: stopped, count held.
- Per-edge priority: clear > start_stop > lap. Lower-priority pulses in the same cycle are ignored.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE, and lap_active is cleared.
  - PAUSE + start_stop -> RUN.
  - PAUSE or IDLE + clear -> IDLE, with count, prescaler and ovf zeroed.
  - RUN + clear is ignored.
  - RUN + lap: if lap_active=0, latch the current count into the lap register and set lap_active=1; otherwise set lap_active=0.
  - lap in IDLE or PAUSE is ignored.
- All outputs are registered. A pulse at edge N is reflected in running and lap_active after edge N.
- Prescaler: counts 0..DIV-1 only in RUN and wraps to 0. It holds its value in PAUSE (resume keeps sub-tick phase) and is 0 in IDLE.
  - tick = RUN && prescaler==DIV-1.
  - The first increment occurs on the DIV-th edge after entering RUN from IDLE.
- BCD count: advances by one on each tick edge.
  - Digit limits: cs 0..9/0..9, s 0..9/0..5, min 0..9/0..5, h 0..9/0..9.
  - Carry ripples combinationally within the same edge.
  - 99:59:59.99 + tick -> 00:00:00.00, ovf=1, and state stays RUN.
  - Digits never hold a non-BCD value.
- If start_stop leaves RUN on the same edge where tick=1, the tick still takes effect (the count advances on that edge).
- digits output = lap_active ? lap register : live count, registered, so it is valid from the edge that updates its source.
- The lap register latches the count value after any same-edge tick (post-increment value).

Decomposition:
- Shared constants go in library.v: state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and digit limits (9, 5).
- One natural sub-module, de2_115_bcd_digit: 4-bit BCD counter with parameter MAX, inputs clk, rst_n, clr, inc; outputs q and carry (inc && q==MAX). Instantiate it 8 times in a chain.
- The FSM, prescaler, lap register and output mux stay in the top of this block.

Test Plan:
- Use CLK_HZ=1000, TICK_HZ=100 (DIV=10).
- Reset then idle 50 cycles -> digits=32'h0, running=0, ovf=0. Assert rst_n=0 mid-RUN -> all outputs 0 on the next edge.
- start_stop at edge N -> running=1 after N; digits=32'h00000001 after edge N+10; 32'h00000010 after edge N+100.
- Run 1000 ticks, then start_stop -> state PAUSE, digits=32'h00001000 (10.00 s) and held for 500 cycles. clear -> digits=0, state IDLE. clear pulsed during RUN -> no change.
- Lap in RUN at count 32'h00000500 -> lap_active=1 and digits frozen at 0500 for 300 cycles. Second lap -> digits jump to the live count 32'h00000800.
- Force the count to 32'h99595999, then one tick -> digits=0, ovf=1, running=1. start_stop+clear in the same cycle while in PAUSE -> IDLE with digits=0 (clear wins).
- start_stop and lap in the same RUN cycle -> PAUSE, lap_active=0. Pause at prescaler=7, resume -> next increment after 3 edges.

Source files
------------

// File: rtl/de2_115_stopwatch_ctrl_pkg.sv
// Shared constants for the DE2-115 stopwatch: FSM encodings, BCD digit limits
// and the single-digit BCD step used by both the digit counters and the top.
package de2_115_stopwatch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] DIGIT_MAX9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX5 = 4'd5;

  // Values at or above the limit wrap to zero, so a digit can never leave BCD range.
  function automatic logic [3:0] bcd_next(input logic [3:0] q, input logic clr,
                                          input logic inc, input logic [3:0] max);
    logic [3:0] r;
    if (clr) begin
      r = 4'd0;
    end else if (inc) begin
      r = (q >= max) ? 4'd0 : q + 4'd1;
    end else begin
      r = q;
    end
    return r;
  endfunction

endpackage

// File: rtl/de2_115_stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the stopwatch count; carry requests an increment of the
// next digit in the same edge.
module de2_115_bcd_digit
  import de2_115_stopwatch_ctrl_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= 4'd0;
    end else begin
      q_r <= bcd_next(q_r, clr, inc, MAX);
    end
  end

  assign q     = q_r;
  assign carry = inc && (q_r == MAX);

endmodule

// File: rtl/de2_115_stopwatch_ctrl.sv
// Stopwatch sequencer: START/STOP/LAP/CLEAR FSM, tick prescaler, 8-digit
// HH:MM:SS.cc BCD count, lap latch and registered display/status outputs.
module de2_115_stopwatch_ctrl
  import de2_115_stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [31:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [1:0]    state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [31:0]   lap_r, lap_s, digits_r, digits_s;
  logic [31:0]   count_s, count_next_s;
  logic          lap_active_r, lap_active_s, running_r, ovf_r, ovf_s;
  logic [7:0]    inc_s, carry_s;
  logic          tick_s, clr_act_s, ss_act_s, lap_act_s;

  // Effective pulse actions after priority (clear > start_stop > lap); clear is a no-op in RUN.
  always_comb begin
    tick_s    = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
    clr_act_s = clear && (state_r != ST_RUN);
    ss_act_s  = start_stop && !clr_act_s;
    lap_act_s = lap && !start_stop && !clr_act_s && (state_r == ST_RUN);
  end

  assign inc_s = {carry_s[6:0], tick_s};

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_dig
      localparam logic [3:0] LIM = (k == 3 || k == 5) ? DIGIT_MAX5 : DIGIT_MAX9;
      de2_115_bcd_digit #(.MAX(LIM)) u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_act_s),
        .inc   (inc_s[k]),
        .q     (count_s[4*k +: 4]),
        .carry (carry_s[k])
      );
      // Post-edge count, so the lap latch and display see a same-edge tick.
      assign count_next_s[4*k +: 4] = bcd_next(count_s[4*k +: 4], clr_act_s, inc_s[k], LIM);
    end
  endgenerate

  // Next-state, prescaler, lap and overflow logic.
  always_comb begin
    case (state_r)
      ST_IDLE:  state_s = ss_act_s ? ST_RUN : ST_IDLE;
      ST_RUN:   state_s = ss_act_s ? ST_PAUSE : ST_RUN;
      ST_PAUSE: state_s = clr_act_s ? ST_IDLE : (ss_act_s ? ST_RUN : ST_PAUSE);
      default:  state_s = ST_IDLE;
    endcase

    if (state_r == ST_RUN) begin
      presc_s = tick_s ? '0 : presc_r + 1'b1;
    end else if (clr_act_s || state_r == ST_IDLE) begin
      presc_s = '0;
    end else begin
      presc_s = presc_r;
    end

    lap_s        = lap_r;
    lap_active_s = lap_active_r;
    if (clr_act_s || (ss_act_s && state_r == ST_RUN)) begin
      lap_active_s = 1'b0;
    end else if (lap_act_s) begin
      if (!lap_active_r) begin
        lap_s        = count_next_s;
        lap_active_s = 1'b1;
      end else begin
        lap_active_s = 1'b0;
      end
    end else begin
      lap_active_s = lap_active_r;
    end

    if (clr_act_s) begin
      ovf_s = 1'b0;
    end else if (carry_s[7]) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end

    digits_s = lap_active_s ? lap_s : count_next_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      presc_r      <= '0;
      lap_r        <= 32'd0;
      lap_active_r <= 1'b0;
      running_r    <= 1'b0;
      ovf_r        <= 1'b0;
      digits_r     <= 32'd0;
    end else begin
      state_r      <= state_s;
      presc_r      <= presc_s;
      lap_r        <= lap_s;
      lap_active_r <= lap_active_s;
      running_r    <= (state_s == ST_RUN);
      ovf_r        <= ovf_s;
      digits_r     <= digits_s;
    end
  end

  assign digits     = digits_r;
  assign running    = running_r;
  assign lap_active = lap_active_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_de2_115_stopwatch_ctrl.sv
// Scoreboard bench for de2_115_stopwatch_ctrl at DIV=10: stimulus queues the
// expected outputs for a given edge, a negedge monitor pops and compares them.
module tb_de2_115_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] digits;
  logic        running, lap_active, ovf;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          when;
    string       name;
    logic [31:0] d;
    logic        r;
    logic        l;
    logic        o;
  } exp_t;

  exp_t sb[$];

  de2_115_stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation, kept sorted by edge number.
  task automatic exp_at(input int when, input string name, input logic [31:0] d,
                        input logic r, input logic l, input logic o);
    exp_t e;
    int   i;
    e.when = when; e.name = name; e.d = d; e.r = r; e.l = l; e.o = o;
    i = 0;
    while (i < sb.size() && sb[i].when <= when) i++;
    sb.insert(i, e);
  endtask

  // Monitor: outputs after edge N are checked on the following falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.when != cyc) begin
        miscompares++;
        $display("FAIL %s: checked at edge %0d, required at edge %0d", e.name, cyc, e.when);
      end else if (digits !== e.d || running !== e.r || lap_active !== e.l || ovf !== e.o) begin
        miscompares++;
        $display("FAIL %s @edge %0d: got digits=%h running=%b lap_active=%b ovf=%b, want digits=%h running=%b lap_active=%b ovf=%b",
                 e.name, cyc, digits, running, lap_active, ovf, e.d, e.r, e.l, e.o);
      end
    end
  end

  task automatic goto_edge(input int target);
    if (cyc > target) begin
      miscompares++;
      $display("FAIL schedule: at edge %0d, wanted edge %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive pulses so they are sampled on edge edge_n.
  task automatic pulse_at(input int edge_n, input logic s, input logic l, input logic c);
    goto_edge(edge_n - 1);
    start_stop = s; lap = l; clear = c;
    @(posedge clk);
    #1;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic reset_at(input int edge_n);
    goto_edge(edge_n - 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, s, r, t, u, spin;
    repeat (3) @(posedge clk);
    #1;
    exp_at(3, "reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    goto_edge(53);
    exp_at(53, "idle_50", 32'h0, 1'b0, 1'b0, 1'b0);

    n = 60;
    pulse_at(n, 1'b1, 1'b0, 1'b0);
    exp_at(n,       "start",       32'h0,  1'b1, 1'b0, 1'b0);
    exp_at(n + 9,   "before_tick", 32'h0,  1'b1, 1'b0, 1'b0);
    exp_at(n + 10,  "first_tick",  32'h1,  1'b1, 1'b0, 1'b0);
    exp_at(n + 100, "ten_cs",      32'h10, 1'b1, 1'b0, 1'b0);
    pulse_at(n + 55, 1'b0, 1'b0, 1'b1);
    exp_at(n + 55, "clear_in_run", 32'h5, 1'b1, 1'b0, 1'b0);

    // Pause lands on the 1000th tick edge; that tick must still count.
    p = n + 10000;
    pulse_at(p, 1'b1, 1'b0, 1'b0);
    exp_at(p,       "pause_10s",  32'h1000, 1'b0, 1'b0, 1'b0);
    exp_at(p + 500, "pause_hold", 32'h1000, 1'b0, 1'b0, 1'b0);
    pulse_at(p + 510, 1'b0, 1'b0, 1'b1);
    exp_at(p + 510, "clear_pause", 32'h0, 1'b0, 1'b0, 1'b0);

    s = p + 520;
    pulse_at(s, 1'b1, 1'b0, 1'b0);
    exp_at(s, "restart", 32'h0, 1'b1, 1'b0, 1'b0);
    pulse_at(s + 5000, 1'b0, 1'b1, 1'b0);
    exp_at(s + 5000, "lap_on",     32'h500, 1'b1, 1'b1, 1'b0);
    exp_at(s + 5300, "lap_frozen", 32'h500, 1'b1, 1'b1, 1'b0);
    pulse_at(s + 8000, 1'b0, 1'b1, 1'b0);
    exp_at(s + 8000, "lap_off", 32'h800, 1'b1, 1'b0, 1'b0);
    pulse_at(s + 8003, 1'b0, 1'b1, 1'b0);
    exp_at(s + 8003, "lap_on2", 32'h800, 1'b1, 1'b1, 1'b0);
    // Prescaler reads 7 after this edge and is held through the pause.
    pulse_at(s + 8007, 1'b1, 1'b1, 1'b0);
    exp_at(s + 8007, "ss_and_lap", 32'h800, 1'b0, 1'b0, 1'b0);
    pulse_at(s + 8020, 1'b0, 1'b1, 1'b0);
    exp_at(s + 8020, "lap_in_pause", 32'h800, 1'b0, 1'b0, 1'b0);

    r = s + 8030;
    pulse_at(r, 1'b1, 1'b0, 1'b0);
    exp_at(r,     "resume",         32'h800, 1'b1, 1'b0, 1'b0);
    exp_at(r + 2, "resume_no_tick", 32'h800, 1'b1, 1'b0, 1'b0);
    exp_at(r + 3, "resume_tick",    32'h801, 1'b1, 1'b0, 1'b0);

    // Preload 99:59:59.99 just before the tick edge r+13.
    goto_edge(r + 12);
    exp_at(r + 13, "wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    force dut.g_dig[0].u_dig.q_r = 4'd9;
    force dut.g_dig[1].u_dig.q_r = 4'd9;
    force dut.g_dig[2].u_dig.q_r = 4'd9;
    force dut.g_dig[3].u_dig.q_r = 4'd5;
    force dut.g_dig[4].u_dig.q_r = 4'd9;
    force dut.g_dig[5].u_dig.q_r = 4'd5;
    force dut.g_dig[6].u_dig.q_r = 4'd9;
    force dut.g_dig[7].u_dig.q_r = 4'd9;
    #1;
    release dut.g_dig[0].u_dig.q_r;
    release dut.g_dig[1].u_dig.q_r;
    release dut.g_dig[2].u_dig.q_r;
    release dut.g_dig[3].u_dig.q_r;
    release dut.g_dig[4].u_dig.q_r;
    release dut.g_dig[5].u_dig.q_r;
    release dut.g_dig[6].u_dig.q_r;
    release dut.g_dig[7].u_dig.q_r;
    @(posedge clk);
    #1;

    pulse_at(r + 20, 1'b1, 1'b0, 1'b0);
    exp_at(r + 20, "pause_after_wrap", 32'h0, 1'b0, 1'b0, 1'b1);
    pulse_at(r + 30, 1'b1, 1'b0, 1'b1);
    exp_at(r + 30, "ss_clear_pause", 32'h0, 1'b0, 1'b0, 1'b0);

    t = r + 40;
    pulse_at(t, 1'b1, 1'b0, 1'b0);
    exp_at(t + 25, "run_before_reset", 32'h2, 1'b1, 1'b0, 1'b0);
    pulse_at(t + 26, 1'b0, 1'b1, 1'b0);
    exp_at(t + 26, "lap_before_reset", 32'h2, 1'b1, 1'b1, 1'b0);
    reset_at(t + 30);
    exp_at(t + 30, "reset_mid_run", 32'h0, 1'b0, 1'b0, 1'b0);

    u = t + 40;
    exp_at(u - 1, "idle_after_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    pulse_at(u, 1'b1, 1'b0, 1'b0);
    exp_at(u + 9,  "post_reset_pre", 32'h0, 1'b1, 1'b0, 1'b0);
    exp_at(u + 10, "post_reset_tick", 32'h1, 1'b1, 1'b0, 1'b0);

    goto_edge(u + 11);
    spin = 0;
    while (sb.size() > 0 && spin < 20) begin
      @(posedge clk);
      #1;
      spin++;
    end
    if (sb.size() > 0) begin
      miscompares += sb.size();
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
